rq_tlp_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the PCIe requester-request (RQ) stream between up to N_PORTS TLP sources (DMA reader, DMA writer, MSI, host-bridge). It feeds the RQ adapter input (LitePCIe TLP format: header DW0 in tdata[31:0] of the first beat). It also enforces a global non-posted (read) request credit limit so outstanding reads never exceed the tags the completion side can track.

---
 rtl/rq_tlp_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rq_tlp_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rq_tlp_arbiter.sv
// rq_tlp_arbiter: packet-granular round-robin arbiter for the PCIe RQ stream.
// Shares one TLP output between N_PORTS requesters. A packet is never split
// once granted. A global non-posted credit pool keeps outstanding reads within
// the tags the completion side can track. A read that is waiting for a credit
// does not block writes from the other requesters.
module rq_tlp_arbiter #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int N_PORTS    = 4,
   parameter int NP_CREDITS = 32
) (
   input  logic                            user_clk,
   input  logic                            user_reset,
   input  logic [N_PORTS*DATA_WIDTH-1:0]   req_tdata,
   input  logic [N_PORTS*KEEP_WIDTH-1:0]   req_tkeep,
   input  logic [N_PORTS*4-1:0]            req_tuser,
   input  logic [N_PORTS-1:0]              req_tlast,
   input  logic [N_PORTS-1:0]              req_tvalid,
   output logic [N_PORTS-1:0]              req_tready,
   output logic [DATA_WIDTH-1:0]           m_tdata,
   output logic [KEEP_WIDTH-1:0]           m_tkeep,
   output logic [3:0]                      m_tuser,
   output logic                            m_tlast,
   output logic                            m_tvalid,
   input  logic                            m_tready,
   input  logic                            np_cpl_done,
   output logic [7:0]                      np_credits,
   output logic [N_PORTS-1:0]              grant,
   output logic                            credit_err
);

   localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARB,
      ST_LOCKED
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    last_grant;
   logic                first_beat;
   logic [7:0]          credit_cnt;
   logic [N_PORTS-1:0]  eligible;
   logic                found;
   logic [IDX_W-1:0]    winner;
   logic [IDX_W:0]      cand_sum;
   logic [31:0]         owner_idx;
   logic                locked;
   logic                accept;
   logic                consume;

   assign np_credits = credit_cnt;
   assign locked     = (state == ST_LOCKED);
   assign owner_idx  = 32'(last_grant);
   assign accept     = m_tvalid & m_tready;
   assign consume    = locked & first_beat & accept & (m_tdata[31:30] == 2'b00);

   // A port may compete if it has a posted packet, or a read while credits remain
   always_comb begin
      eligible = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         eligible[i] = req_tvalid[i] &&
                       ((req_tdata[i*DATA_WIDTH+30 +: 2] != 2'b00) || (credit_cnt != 8'd0));
      end
   end

   // Search upward from the port after the previous owner so nobody starves
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      cand_sum = '0;
      for (int k = 1; k <= N_PORTS; k++) begin
         cand_sum = {1'b0, last_grant} + (IDX_W+1)'(k);
         if (cand_sum >= (IDX_W+1)'(N_PORTS)) begin
            cand_sum = cand_sum - (IDX_W+1)'(N_PORTS);
         end
         if (!found && eligible[cand_sum[IDX_W-1:0]]) begin
            found  = 1'b1;
            winner = cand_sum[IDX_W-1:0];
         end
      end
   end

   // While locked the owner is wired straight through so stalls cost no cycles
   always_comb begin
      m_tdata    = '0;
      m_tkeep    = '0;
      m_tuser    = '0;
      m_tlast    = 1'b0;
      m_tvalid   = 1'b0;
      req_tready = '0;
      if (locked) begin
         m_tdata                = req_tdata[owner_idx*DATA_WIDTH +: DATA_WIDTH];
         m_tkeep                = req_tkeep[owner_idx*KEEP_WIDTH +: KEEP_WIDTH];
         m_tuser                = req_tuser[owner_idx*4 +: 4];
         m_tlast                = req_tlast[last_grant];
         m_tvalid               = req_tvalid[last_grant];
         req_tready[last_grant] = m_tready;
      end
   end

   // Arbitration state machine; the grant only moves between packets
   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         state      <= ST_IDLE;
         grant      <= '0;
         last_grant <= IDX_W'(N_PORTS - 1);
         first_beat <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req_tvalid) begin
                  state <= ST_ARB;
               end
            end
            ST_ARB: begin
               if (found) begin
                  state      <= ST_LOCKED;
                  last_grant <= winner;
                  grant      <= N_PORTS'(1) << winner;
                  first_beat <= 1'b1;
               end else if (!(|req_tvalid)) begin
                  state <= ST_IDLE;
               end
            end
            ST_LOCKED: begin
               if (accept) begin
                  first_beat <= 1'b0;
               end
               if (accept && m_tlast) begin
                  state <= ST_ARB;
                  grant <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Non-posted credit pool, saturating at both ends, with a sticky overflow flag
   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         credit_cnt <= 8'(NP_CREDITS);
         credit_err <= 1'b0;
      end else if (consume && !np_cpl_done) begin
         if (credit_cnt != 8'd0) begin
            credit_cnt <= credit_cnt - 8'd1;
         end
      end else if (np_cpl_done && !consume) begin
         if (credit_cnt == 8'(NP_CREDITS)) begin
            credit_err <= 1'b1;
         end else begin
            credit_cnt <= credit_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_rq_tlp_arbiter.sv
// tb_rq_tlp_arbiter: directed bench for the RQ round-robin arbiter.
// Per-port source queues feed the requesters; every beat expected on the
// output is pushed to a scoreboard in the order the grants should occur.
module tb_rq_tlp_arbiter;

   localparam int DW  = 512;
   localparam int KW  = DW / 8;
   localparam int NP  = 4;
   localparam int NPC = 32;

   logic              user_clk = 1'b0;
   logic              user_reset;
   logic [NP*DW-1:0]  req_tdata;
   logic [NP*KW-1:0]  req_tkeep;
   logic [NP*4-1:0]   req_tuser;
   logic [NP-1:0]     req_tlast;
   logic [NP-1:0]     req_tvalid;
   logic [NP-1:0]     req_tready;
   logic [DW-1:0]     m_tdata;
   logic [KW-1:0]     m_tkeep;
   logic [3:0]        m_tuser;
   logic              m_tlast;
   logic              m_tvalid;
   logic              m_tready;
   logic              np_cpl_done;
   logic [7:0]        np_credits;
   logic [NP-1:0]     grant;
   logic              credit_err;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [3:0]    user;
      logic          last;
      int            port;
   } beat_t;

   beat_t        src_q [NP][$];
   beat_t        exp_q [$];
   int           acc_cyc [$];
   logic [NP-1:0] fire_r = '0;
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           seq = 0;

   rq_tlp_arbiter #(
      .DATA_WIDTH (DW),
      .KEEP_WIDTH (KW),
      .N_PORTS    (NP),
      .NP_CREDITS (NPC)
   ) dut (
      .user_clk    (user_clk),
      .user_reset  (user_reset),
      .req_tdata   (req_tdata),
      .req_tkeep   (req_tkeep),
      .req_tuser   (req_tuser),
      .req_tlast   (req_tlast),
      .req_tvalid  (req_tvalid),
      .req_tready  (req_tready),
      .m_tdata     (m_tdata),
      .m_tkeep     (m_tkeep),
      .m_tuser     (m_tuser),
      .m_tlast     (m_tlast),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .np_cpl_done (np_cpl_done),
      .np_credits  (np_credits),
      .grant       (grant),
      .credit_err  (credit_err)
   );

   // Free-running clock
   always #5 user_clk = ~user_clk;

   // Cycle counter used to measure beat spacing
   always @(posedge user_clk) cyc <= cyc + 1;

   // Global time limit so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge user_clk);
      #1;
   endtask

   // Queue one packet on a source; the first exp_beats beats go to the scoreboard
   task automatic apply_stimulus(input int port, input logic is_read, input int nbeats,
                                 input logic disc, input int exp_beats);
      beat_t b;
      for (int i = 0; i < nbeats; i++) begin
         for (int w = 0; w < DW/32; w++) b.data[w*32 +: 32] = $urandom;
         if (i == 0) begin
            b.data[31:30] = is_read ? 2'b00 : 2'b10;
            b.data[63:32] = {8'(port), 24'(seq)};
            seq++;
         end
         b.last = (i == nbeats - 1);
         b.keep = b.last ? ({KW{1'b1}} >> $urandom_range(0, KW-1)) : {KW{1'b1}};
         b.user = {disc, 1'b0, 2'($urandom_range(0, 3))};
         b.port = port;
         src_q[port].push_back(b);
         if (i < exp_beats) exp_q.push_back(b);
      end
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick(1);
         n++;
      end
      tick(2);
      check_output({"drain_", tag}, DW'(exp_q.size()), '0);
   endtask

   task automatic pulse_cpl();
      np_cpl_done = 1'b1;
      tick(1);
      np_cpl_done = 1'b0;
      tick(1);
   endtask

   // Monitor: capture handshakes and score every accepted output beat
   initial begin
      beat_t e;
      forever begin
         @(negedge user_clk);
         fire_r = req_tvalid & req_tready;
         if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            check_output("beat_pending", DW'(exp_q.size() != 0), DW'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               acc_cyc.push_back(cyc);
               check_output("beat_data", m_tdata, e.data);
               check_output("beat_ctl", DW'({m_tkeep, m_tuser, m_tlast}), DW'({e.keep, e.user, e.last}));
               check_output("beat_grant", DW'(grant), DW'(NP'(1) << e.port));
            end
         end
      end
   end

   // Source model: retire accepted heads, present the next beat of each port
   initial begin
      req_tdata  = '0;
      req_tkeep  = '0;
      req_tuser  = '0;
      req_tlast  = '0;
      req_tvalid = '0;
      forever begin
         @(posedge user_clk);
         #2;
         for (int p = 0; p < NP; p++) begin
            if (fire_r[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
            if (src_q[p].size() > 0) begin
               req_tvalid[p]          = 1'b1;
               req_tdata[p*DW +: DW]  = src_q[p][0].data;
               req_tkeep[p*KW +: KW]  = src_q[p][0].keep;
               req_tuser[p*4 +: 4]    = src_q[p][0].user;
               req_tlast[p]           = src_q[p][0].last;
            end else begin
               req_tvalid[p]          = 1'b0;
               req_tdata[p*DW +: DW]  = '0;
               req_tkeep[p*KW +: KW]  = '0;
               req_tuser[p*4 +: 4]    = '0;
               req_tlast[p]           = 1'b0;
            end
         end
      end
   end

   // Directed sequence
   initial begin
      int n;
      user_reset  = 1'b1;
      m_tready    = 1'b1;
      np_cpl_done = 1'b0;
      tick(3);
      user_reset = 1'b0;
      tick(1);

      $display("[TB] reset values");
      check_output("rst_grant", DW'(grant), '0);
      check_output("rst_tready", DW'(req_tready), '0);
      check_output("rst_mvalid", DW'(m_tvalid), '0);
      check_output("rst_credits", DW'(np_credits), DW'(NPC));
      check_output("rst_cerr", DW'(credit_err), '0);

      $display("[TB] single 3-beat write on port 0");
      acc_cyc.delete();
      apply_stimulus(0, 1'b0, 3, 1'b0, 3);
      tick(1);
      check_output("t1_grant_arb", DW'(grant), '0);
      tick(1);
      check_output("t1_grant", DW'(grant), DW'(4'b0001));
      wait_drain("t1", 20);
      n = acc_cyc.size();
      check_output("t1_nbeats", DW'(n), DW'(3));
      if (n == 3) check_output("t1_back_to_back", DW'(acc_cyc[2] - acc_cyc[0]), DW'(2));
      check_output("t1_credits", DW'(np_credits), DW'(NPC));
      check_output("t1_grant_idle", DW'(grant), '0);

      $display("[TB] round robin with all ports busy");
      acc_cyc.delete();
      for (int r = 0; r < 2; r++) begin
         apply_stimulus(1, 1'b0, 1, 1'b0, 1);
         apply_stimulus(2, 1'b0, 1, 1'b1, 1);
         apply_stimulus(3, 1'b0, 1, 1'b0, 1);
         apply_stimulus(0, 1'b0, 1, 1'b1, 1);
      end
      wait_drain("t2", 100);
      check_output("t2_nbeats", DW'(acc_cyc.size()), DW'(8));
      for (int i = 1; i < acc_cyc.size(); i++) begin
         check_output($sformatf("t2_gap%0d", i), DW'(acc_cyc[i] - acc_cyc[i-1]), DW'(2));
      end

      $display("[TB] read credit exhaustion");
      for (int i = 0; i < NPC - 2; i++) apply_stimulus(1, 1'b1, 1, 1'b0, 1);
      wait_drain("t3a", 300);
      check_output("t3_credits_2", DW'(np_credits), DW'(2));
      apply_stimulus(2, 1'b0, 1, 1'b0, 1);
      apply_stimulus(1, 1'b1, 1, 1'b0, 1);
      apply_stimulus(2, 1'b0, 1, 1'b0, 1);
      apply_stimulus(1, 1'b1, 1, 1'b0, 1);
      apply_stimulus(1, 1'b1, 1, 1'b0, 0);
      wait_drain("t3b", 60);
      check_output("t3_credits_0", DW'(np_credits), '0);
      tick(4);
      check_output("t3_blocked_grant", DW'(grant), '0);
      check_output("t3_blocked_tready", DW'(req_tready), '0);
      check_output("t3_blocked_mvalid", DW'(m_tvalid), '0);
      apply_stimulus(2, 1'b0, 2, 1'b0, 2);
      wait_drain("t3_write_passes", 30);
      check_output("t3_credits_still_0", DW'(np_credits), '0);
      if (src_q[1].size() > 0) exp_q.push_back(src_q[1][0]);
      pulse_cpl();
      wait_drain("t3c", 30);
      check_output("t3_credits_after_read", DW'(np_credits), '0);

      $display("[TB] simultaneous consume and completion");
      repeat (5) pulse_cpl();
      check_output("t4_credits_5", DW'(np_credits), DW'(5));
      m_tready = 1'b0;
      apply_stimulus(3, 1'b1, 1, 1'b0, 1);
      n = 0;
      while (grant !== 4'b1000 && n < 20) begin
         tick(1);
         n++;
      end
      check_output("t4_grant", DW'(grant), DW'(4'b1000));
      m_tready    = 1'b1;
      np_cpl_done = 1'b1;
      tick(1);
      np_cpl_done = 1'b0;
      check_output("t4_credits_net", DW'(np_credits), DW'(5));
      wait_drain("t4", 10);

      $display("[TB] credit overflow");
      repeat (NPC - 5) pulse_cpl();
      check_output("t5_credits_full", DW'(np_credits), DW'(NPC));
      check_output("t5_cerr_clear", DW'(credit_err), '0);
      pulse_cpl();
      check_output("t5_credits_sat", DW'(np_credits), DW'(NPC));
      check_output("t5_cerr_set", DW'(credit_err), DW'(1));
      tick(5);
      check_output("t5_cerr_held", DW'(credit_err), DW'(1));

      $display("[TB] ready toggling and reset mid-packet");
      acc_cyc.delete();
      apply_stimulus(0, 1'b0, 4, 1'b0, 4);
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         m_tready = ~m_tready;
         tick(1);
         n++;
      end
      m_tready = 1'b1;
      tick(2);
      check_output("t6_drain", DW'(exp_q.size()), '0);
      check_output("t6_nbeats", DW'(acc_cyc.size()), DW'(4));
      for (int i = 1; i < acc_cyc.size(); i++) begin
         check_output($sformatf("t6_gap%0d", i), DW'(acc_cyc[i] - acc_cyc[i-1]), DW'(2));
      end

      apply_stimulus(2, 1'b1, 4, 1'b0, 2);
      n = 0;
      while (exp_q.size() > 1 && n < 20) begin
         tick(1);
         n++;
      end
      check_output("t6_rd_credit", DW'(np_credits), DW'(NPC - 1));
      user_reset = 1'b1;
      tick(1);
      src_q[2].delete();
      tick(1);
      user_reset = 1'b0;
      tick(1);
      check_output("t6_rst_grant", DW'(grant), '0);
      check_output("t6_rst_credits", DW'(np_credits), DW'(NPC));
      check_output("t6_rst_mvalid", DW'(m_tvalid), '0);
      check_output("t6_rst_cerr", DW'(credit_err), '0);
      check_output("t6_rst_tready", DW'(req_tready), '0);
      check_output("t6_rst_pending", DW'(exp_q.size()), '0);

      $display("[TB] port 0 wins first after reset");
      apply_stimulus(0, 1'b0, 1, 1'b0, 1);
      apply_stimulus(1, 1'b0, 1, 1'b0, 1);
      wait_drain("t7", 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
